// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: shared pipeline types for skid-buffered stages
package pipe_skid_stage_pkg;
  localparam int OCC_W = 2;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;
  function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
    return s == FULL ? 2'd2 : s == ONE ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer with registered handshake, flush and stall statistics
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  skid_state_t state, state_nxt;
  logic [DATA_W-1:0] skid;
  logic in_fire, out_fire, main_from_in, main_from_skid, skid_from_in;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign main_from_in = !flush & in_fire & (state == EMPTY | (state == ONE & out_fire));
  assign main_from_skid = !flush & out_fire & state == FULL;
  assign skid_from_in = !flush & in_fire & !out_fire & state == ONE;
  // next state; flush squashes everything, including a beat accepted this cycle
  always_comb begin
    state_nxt = flush ? EMPTY :
                state == EMPTY ? (in_fire ? ONE : EMPTY) :
                state == ONE ? (in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : ONE) :
                (out_fire ? ONE : FULL);
  end
  // state, registered handshake outputs and payload registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= '0;
      out_data  <= RESET_VALUE;
      skid      <= RESET_VALUE;
    end else begin
      state     <= state_nxt;
      out_valid <= state_nxt != EMPTY;
      in_ready  <= state_nxt != FULL;
      occupancy <= occ_of(state_nxt);
      out_data  <= main_from_in ? in_data : main_from_skid ? skid : out_data;
      skid      <= skid_from_in ? in_data : skid;
    end
  end
  // saturating count of cycles where a held beat is refused downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else if (clr_stats) stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: payload width in bits.
REQ-002 SHALL provide parameter RESET_VALUE, default 0: value loaded into every payload register on reset.
REQ-003 SHALL provide parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: upstream beat present.
REQ-007 SHALL have port in_data  input  DATA_W: upstream payload.
REQ-008 SHALL have port in_ready  output  1: stage can accept a beat; driven only from registered state.
REQ-009 SHALL have port out_valid  output  1: downstream beat present.
REQ-010 SHALL have port out_data  output  DATA_W: downstream payload; driven directly from the main register.
REQ-011 SHALL have port out_ready  input  1: downstream accepts the beat.
REQ-012 SHALL have port flush  input  1: synchronous kill of all held beats, for branch-taken or exception squash.
REQ-013 SHALL have port clr_stats  input  1: synchronous clear of stall_cnt.
REQ-014 SHALL have port occupancy  output  2: number of held beats, 0..2.
REQ-015 SHALL have port stall_cnt  output  CNT_W: cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-017 SHALL hold two payload registers: main (drives out_data) and skid.
REQ-018 SHALL implement states EMPTY (occupancy 0), ONE (1) and FULL (2); out_valid=1 in ONE and FULL; in_ready=0 only in FULL.
REQ-019 EMPTY: on in_fire, main<=in_data and go to ONE; otherwise stay in EMPTY.
REQ-020 ONE: on in_fire & out_fire, main<=in_data and stay in ONE; on in_fire only, skid<=in_data and go to FULL; on out_fire only, go to EMPTY.
REQ-021 FULL: on out_fire, main<=skid and go to ONE; otherwise hold both registers and stay in FULL.
REQ-022 SHALL have latency of 1 cycle: a beat accepted in EMPTY appears on out_data/out_valid the next cycle.
REQ-023 SHALL sustain 1 beat/cycle when out_ready is held at 1.
REQ-024 SHALL preserve order and never drop or duplicate a beat except on flush.
REQ-025 SHALL, when flush=1, go to EMPTY next cycle with priority over all transitions; a beat accepted by in_fire in that cycle is discarded; payload registers keep their contents.
REQ-026 SHALL keep in_ready=1 in the cycle after a flush.
REQ-027 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment stall_cnt by 1 each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 with no wrap-around.
REQ-029 SHALL let clr_stats take priority over an increment in the same cycle, giving stall_cnt=0.

Reset
REQ-030 SHALL, on reset, immediately and asynchronously force the state to EMPTY, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0, and main and skid to RESET_VALUE.
REQ-031 SHALL, when reset asserts mid-transfer, discard held beats; the first edge after deassertion behaves as from EMPTY.

Structure
REQ-032 SHALL place the state encoding (EMPTY=0, ONE=1, FULL=2) in the shared pipeline package.
REQ-033 SHALL be a single module; pipeline stages SHALL chain instances of it, with no sub-module.

Verification
REQ-034 Verify reset: assert reset mid-FULL -> out_valid=0, in_ready=1, out_data=RESET_VALUE at once, with no clock edge.
REQ-035 Verify streaming: out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after input, stall_cnt=0.
REQ-036 Verify backpressure: out_ready=0, push 0xA, 0xB -> occupancy=2, in_ready=0; 0xC held off; raise out_ready -> outputs in order 0xA, 0xB, 0xC.
REQ-037 Verify flush: in FULL (0xA, 0xB), flush=1 with in_valid=1, in_data 0xC -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC never emitted.
REQ-038 Verify saturation: CNT_W=4, out_ready=0 for 20 cycles with a beat held -> stall_cnt=15; clr_stats together with a stall -> stall_cnt=0.
REQ-039 Verify random ready/valid: run 10k beats -> scoreboard shows order and count intact and no payload change while stalled.
